// File: rtl/rnd_sched_pkg.sv
// Shared definitions for the randomness buffer / reseed scheduler:
// FSM state encoding and width helpers for the occupancy and reseed counters.
package rnd_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_FILL = 3'd3,
        ST_RUN  = 3'd4
    } sched_state_e;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to count pops up to and including period.
    function automatic int unsigned count_width(input int unsigned period);
        return $clog2(period + 1);
    endfunction

endpackage

// File: rtl/rnd_fifo.sv
// Randomness word FIFO: storage array, wrapping pointers, exact level counter
// and a synchronous flush that empties the FIFO without touching storage.
module rnd_fifo
    import rnd_sched_pkg::*;
#(
    parameter int unsigned RND_W = 680,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  logic                          pop,
    input  logic [RND_W-1:0]              wr_data,
    output logic [RND_W-1:0]              rd_data,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = level_width(DEPTH);

    logic [RND_W-1:0] mem_q [DEPTH];
    logic [RND_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/rnd_buffer_sched.sv
// Randomness buffer and PRNG reseed scheduler: FSM plus optional pop-count
// auto reseed, enabled by defining RND_AUTO_RESEED_EN.
module rnd_buffer_sched
    import rnd_sched_pkg::*;
#(
    parameter int unsigned RND_W         = 680,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned RESEED_PERIOD = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_reseed,
    output logic                          prng_start_reseed,
    input  logic                          prng_busy,
    input  logic [RND_W-1:0]              in_rnd,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [RND_W-1:0]              out_rnd,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int unsigned LVL_W    = level_width(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RESEED_PERIOD < 1) begin : g_param_check
        $error("rnd_buffer_sched: DEPTH must be a power of two >= 2 and RESEED_PERIOD >= 1");
    end

    sched_state_e state_q, state_d;
    logic         flush;
    logic         push;
    logic         pop;
    logic         auto_hit;

    rnd_fifo #(
        .RND_W (RND_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (in_rnd),
        .rd_data (out_rnd),
        .level   (level)
    );

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

`ifdef RND_AUTO_RESEED_EN
    localparam int unsigned CNT_W = count_width(RESEED_PERIOD);
    localparam logic [CNT_W-1:0] PERIOD_CNT = CNT_W'(RESEED_PERIOD);

    logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;

    always_comb begin
        pop_cnt_d = pop_cnt_q;
        if (state_q == ST_REQ) begin
            pop_cnt_d = '0;
        end else if (pop) begin
            pop_cnt_d = pop_cnt_q + 1'b1;
        end
    end

    // Reaching the period always forces REQ, which clears the count, so it never overflows.
    assign auto_hit = pop && (pop_cnt_d == PERIOD_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_cnt_q <= '0;
        end else begin
            pop_cnt_q <= pop_cnt_d;
        end
    end
`else
    assign auto_hit = 1'b0;
`endif

    always_comb begin
        state_d           = state_q;
        prng_start_reseed = 1'b0;
        busy              = 1'b0;
        in_ready          = 1'b0;
        out_valid         = 1'b0;
        flush             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_reseed) state_d = ST_REQ;
            end
            ST_REQ: begin
                prng_start_reseed = 1'b1;
                busy              = 1'b1;
                flush             = 1'b1;
                state_d           = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (!prng_busy) state_d = ST_FILL;
            end
            ST_FILL: begin
                busy     = 1'b1;
                in_ready = (level < FULL_LVL);
                if (start_reseed) begin
                    state_d = ST_REQ;
                end else if (level == FULL_LVL) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // in_ready depends only on the registered level, never on out_ready.
                in_ready  = (level < FULL_LVL);
                out_valid = (level != '0);
                if (start_reseed || auto_hit) state_d = ST_REQ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
